fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops bytes from an upstream FIFO and sends them as UART frames,
//            8N1 by default or 8E1 when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       empty_flag,
    input  logic [7:0] data_out,
    output logic       read_en,
    output logic       tx,
    output logic       busy
);

    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd6
    } state_t;
`endif

    state_t        r_state,   w_state_nxt;
    logic          r_read_en, w_read_en_nxt;
    logic          r_tx,      w_tx_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]    r_idx,     w_idx_nxt;
    logic [7:0]    r_shift,   w_shift_nxt;
    logic          w_bit_done;

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity is taken from the byte as loaded, before shifting destroys it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_parity <= ^data_out;
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_read_en_nxt = 1'b0;
        w_tx_nxt      = r_tx;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_bit_done    = (r_cnt == c_BIT_LAST);

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (tx_enable && !empty_flag) begin
                    w_read_en_nxt = 1'b1;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nxt = data_out;
                w_tx_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = r_parity;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_read_en <= 1'b0;
            r_tx      <= 1'b1;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_read_en <= w_read_en_nxt;
            r_tx      <= w_tx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    assign read_en = r_read_en;
    assign tx      = r_tx;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Scoreboard bench for fifo_uart_tx with a behavioural FIFO and a
//            serial-line decoder. Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       empty_flag;
    logic [7:0] data_out = 8'h00;
    logic       read_en;
    logic       tx;
    logic       busy;

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .empty_flag (empty_flag),
        .data_out   (data_out),
        .read_en    (read_en),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: pop data valid for one cycle after read_en, garbage otherwise.
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign empty_flag = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (read_en) begin
            data_out <= mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end else begin
            data_out <= 8'($urandom);
        end
    end

    logic [7:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_fifo(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic push(input logic [7:0] b);
        push_fifo(b);
        exp_q.push_back(b);
    endtask

    // Serial decoder / timing monitor
    logic        mon_active     = 1'b0;
    int          mon_cnt        = 0;
    logic [10:0] mon_bits       = '0;
    logic        mon_bad        = 1'b0;
    logic        ren_prev       = 1'b0;
    int          ren_cyc        = 0;
    int          ren_pulses     = 0;
    int          stop_cyc       = -1;
    int          tx_en_rise_cyc = -1;
    logic        gap_chk        = 1'b0;
    logic [7:0]  exp_b;

    initial begin
        forever begin
            @(negedge clk);
            if (read_en) check_val("read_en_one_cycle", {31'b0, ren_prev}, 0);
            if (read_en && !ren_prev) begin
                ren_pulses++;
                ren_cyc = cyc;
            end
            ren_prev = read_en;
            if (!reset) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_bad    = 1'b0;
                    mon_bits   = '0;
                    check_val("read_en_to_start", cyc - ren_cyc, 2);
                    if (gap_chk && stop_cyc >= 0) check_val("stop_to_start_gap", cyc - stop_cyc, N + 3);
                    if (tx_en_rise_cyc >= 0) begin
                        check_val("enable_to_start", cyc - tx_en_rise_cyc, 3);
                        tx_en_rise_cyc = -1;
                    end
                end
                if (mon_active) begin
                    if (mon_cnt < FB * N) begin
                        if (mon_cnt % N == 0) mon_bits[mon_cnt / N] = tx;
                        else if (tx !== mon_bits[mon_cnt / N]) mon_bad = 1'b1;
                        if (!busy) mon_bad = 1'b1;
                        if (mon_cnt == (FB - 1) * N) stop_cyc = cyc;
                    end else begin
                        check_val("frame_end_busy", {31'b0, busy}, 0);
                        check_val("frame_end_tx", {31'b0, tx}, 1);
                        check_val("bit_hold_and_busy", {31'b0, mon_bad}, 0);
                        check_val("start_bit", {31'b0, mon_bits[0]}, 0);
                        check_val("stop_bit", {31'b0, mon_bits[FB-1]}, 1);
                        check_val("sb_pending", {31'b0, exp_q.size() != 0}, 1);
                        if (exp_q.size() != 0) begin
                            exp_b = exp_q.pop_front();
                            check_val("data_byte", {24'b0, mon_bits[8:1]}, {24'b0, exp_b});
`ifdef UART_TX_PARITY_EN
                            check_val("parity_bit", {31'b0, mon_bits[9]}, {31'b0, ^exp_b});
`endif
                        end
                        mon_active = 1'b0;
                    end
                    mon_cnt++;
                end
            end
        end
    end

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !mon_active) break;
        end
        check_val("drain_timeout", exp_q.size(), 0);
    endtask

    logic bad;

    initial begin
        reset     = 1'b0;
        tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", {31'b0, tx}, 1);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_read_en", {31'b0, read_en}, 0);
        reset = 1'b1;

        // Single frame, alternating pattern
        @(negedge clk);
        push(8'h55);
        tx_enable = 1'b1;
        wait_done(200);

        // 0x07 plus random bytes, back to back
        push(8'h07);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        wait_done(800);

        // Enable drops right after the pop: byte must still go out
        @(negedge clk);
        push(8'hC6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (read_en) break;
        end
        check_val("read_en_seen", {31'b0, read_en}, 1);
        tx_enable = 1'b0;
        wait_done(200);

        // Preloaded FIFO with enable held off, then a burst of 8 frames
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'(i));
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (read_en || !tx || busy) bad = 1'b1;
        end
        check_val("hold_off_idle", {31'b0, bad}, 0);
        ren_pulses     = 0;
        stop_cyc       = -1;
        gap_chk        = 1'b1;
        tx_enable      = 1'b1;
        tx_en_rise_cyc = cyc;
        wait_done(8 * (FB * N + 10));
        gap_chk = 1'b0;
        check_val("burst_read_pulses", ren_pulses, 8);
        check_val("burst_fifo_empty", {31'b0, empty_flag}, 1);
        check_val("burst_busy", {31'b0, busy}, 0);

        // Asynchronous reset mid-frame
        @(negedge clk);
        push_fifo(8'hA3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx) break;
        end
        check_val("abort_frame_started", {31'b0, tx}, 0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("abort_tx", {31'b0, tx}, 1);
        check_val("abort_busy", {31'b0, busy}, 0);
        check_val("abort_read_en", {31'b0, read_en}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (read_en || !tx || busy) bad = 1'b1;
        end
        check_val("post_reset_idle", {31'b0, bad}, 0);
        check_val("post_reset_fifo_empty", {31'b0, empty_flag}, 1);
        check_val("sb_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
